// File: rtl/stm1_frame_scheduler_pkg.sv
// Shared STM-1 / VC-4 constants, region type and the fixed AU-4 pointer bytes
// for a VC-4 locked at pointer 522.
package stm1_frame_scheduler_pkg;

    localparam int STM1_COLS_C = 270;
    localparam int ROWS_C      = 9;
    localparam int SOH_COLS_C  = 9;

    localparam logic [3:0] PTR_ROW = 4'd3;

    // H1 = NDF(0110) | SS(10) | ptr[9:8], H2 = ptr[7:0]
    localparam logic [9:0] AU4_PTR    = 10'd522;
    localparam logic [3:0] NDF_NORMAL = 4'b0110;
    localparam logic [1:0] SS_AU4     = 2'b10;
    localparam logic [7:0] PTR_H1     = {NDF_NORMAL, SS_AU4, AU4_PTR[9:8]};
    localparam logic [7:0] PTR_Y      = 8'h9B;
    localparam logic [7:0] PTR_H2     = AU4_PTR[7:0];
    localparam logic [7:0] PTR_ONES   = 8'hFF;
    localparam logic [7:0] PTR_H3     = 8'h00;

    typedef enum logic [1:0] {
        REG_SOH     = 2'd0,
        REG_PTR     = 2'd1,
        REG_POH     = 2'd2,
        REG_PAYLOAD = 2'd3
    } region_e;

    function automatic logic [7:0] ptr_byte(input logic [8:0] col);
        case (col)
            9'd0:       ptr_byte = PTR_H1;
            9'd1, 9'd2: ptr_byte = PTR_Y;
            9'd3:       ptr_byte = PTR_H2;
            9'd4, 9'd5: ptr_byte = PTR_ONES;
            default:    ptr_byte = PTR_H3;
        endcase
    endfunction

endpackage

// File: rtl/stm1_frame_scheduler_if.sv
// Byte-source and line-side stream signals between the scheduler (master)
// and the SOH/POH/C-4 generators plus serializer (slave).
interface stm1_frame_scheduler_if
    import stm1_frame_scheduler_pkg::*;
#(
    parameter int BYTE_W = 8
);
    logic [BYTE_W-1:0] soh_data;
    logic              soh_rd;
    logic [BYTE_W-1:0] poh_data;
    logic              poh_rd;
    logic [BYTE_W-1:0] c4_data;
    logic              c4_valid;
    logic              c4_ready;
    logic [BYTE_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_sof;
    region_e           out_region;

    modport master (
        input  soh_data, poh_data, c4_data, c4_valid, out_ready,
        output soh_rd, poh_rd, c4_ready, out_data, out_valid, out_sof, out_region
    );

    modport slave (
        output soh_data, poh_data, c4_data, c4_valid, out_ready,
        input  soh_rd, poh_rd, c4_ready, out_data, out_valid, out_sof, out_region
    );

endinterface

// File: rtl/stm1_frame_scheduler_pos_counter.sv
// Row/column position of the next byte to schedule; frame_tick_o pulses
// the cycle after the last byte of the frame was taken.
module stm1_frame_scheduler_pos_counter #(
    parameter int COLS = 270,
    parameter int ROWS = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       advance_i,
    output logic [3:0] row_o,
    output logic [8:0] col_o,
    output logic       frame_tick_o
);
    localparam logic [8:0] LAST_COL = 9'(COLS - 1);
    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

    logic [3:0] row_q, row_d;
    logic [8:0] col_q, col_d;
    logic       tick_q, tick_d;

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        tick_d = 1'b0;
        if (advance_i) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                if (row_q == LAST_ROW) begin
                    row_d  = '0;
                    tick_d = 1'b1;
                end else begin
                    row_d = row_q + 4'd1;
                end
            end else begin
                col_d = col_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q  <= '0;
            col_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            tick_q <= tick_d;
        end
    end

    assign row_o        = row_q;
    assign col_o        = col_q;
    assign frame_tick_o = tick_q;

endmodule

// File: rtl/stm1_frame_scheduler.sv
// STM-1 frame byte scheduler: walks 270x9 positions, muxes SOH / AU-4 pointer /
// POH / C-4 sources into one registered byte stream with valid/ready backpressure.
module stm1_frame_scheduler
    import stm1_frame_scheduler_pkg::*;
#(
    parameter int                STM1_COLS = STM1_COLS_C,
    parameter int                ROWS      = ROWS_C,
    parameter int                SOH_COLS  = SOH_COLS_C,
    parameter int                BYTE_W    = 8,
    parameter logic [BYTE_W-1:0] FILL_BYTE = '0,
    parameter int                ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    stm1_frame_scheduler_if.master bus,
    output logic [3:0]           row,
    output logic [8:0]           col,
    output logic                 frame_tick,
    output logic [ERR_CNT_W-1:0] underrun_cnt
);
    localparam logic [8:0] OH_COLS = 9'(SOH_COLS);

    logic                 load;
    region_e              region;
    logic [BYTE_W-1:0]    byte_d;
    logic [BYTE_W-1:0]    data_q;
    logic                 valid_q;
    logic                 sof_q;
    region_e              region_q;
    logic [ERR_CNT_W-1:0] und_q, und_d;

    stm1_frame_scheduler_pos_counter #(
        .COLS (STM1_COLS),
        .ROWS (ROWS)
    ) u_pos (
        .clk          (clk),
        .rst_n        (rst_n),
        .advance_i    (load),
        .row_o        (row),
        .col_o        (col),
        .frame_tick_o (frame_tick)
    );

    // Gated by rst_n so no source sees a strobe during a reset cycle.
    assign load = rst_n & en & (~valid_q | bus.out_ready);

    always_comb begin
        region = REG_PAYLOAD;
        if (col < OH_COLS) begin
            region = (row == PTR_ROW) ? REG_PTR : REG_SOH;
        end else if (col == OH_COLS) begin
            region = REG_POH;
        end
    end

    assign bus.soh_rd   = load & (region == REG_SOH);
    assign bus.poh_rd   = load & (region == REG_POH);
    assign bus.c4_ready = load & (region == REG_PAYLOAD);

    // Payload never stalls the frame: a missing C-4 byte becomes FILL_BYTE.
    always_comb begin
        case (region)
            REG_SOH: byte_d = bus.soh_data;
            REG_PTR: byte_d = BYTE_W'(ptr_byte(col));
            REG_POH: byte_d = bus.poh_data;
            default: byte_d = bus.c4_valid ? bus.c4_data : FILL_BYTE;
        endcase
    end

    always_comb begin
        und_d = und_q;
        if (bus.c4_ready && !bus.c4_valid && !(&und_q)) begin
            und_d = und_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            sof_q    <= 1'b0;
            region_q <= REG_SOH;
            und_q    <= '0;
        end else begin
            und_q <= und_d;
            if (load) begin
                valid_q  <= 1'b1;
                data_q   <= byte_d;
                sof_q    <= (row == 4'd0) && (col == 9'd0);
                region_q <= region;
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_data   = data_q;
    assign bus.out_valid  = valid_q;
    assign bus.out_sof    = sof_q;
    assign bus.out_region = region_q;
    assign underrun_cnt   = und_q;

endmodule

// File: tb/tb_stm1_frame_scheduler.sv
// Bench for stm1_frame_scheduler: linear-index frame model checked every cycle,
// plus a landmark table and directed stall/reset/enable/saturation sequences.
module tb_stm1_frame_scheduler;
    import stm1_frame_scheduler_pkg::*;

    localparam int COLS  = 270;
    localparam int FRAME = 2430;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  row;
    logic [8:0]  col;
    logic        frame_tick;
    logic [15:0] underrun_cnt;

    stm1_frame_scheduler_if bus ();

    stm1_frame_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .bus          (bus),
        .row          (row),
        .col          (col),
        .frame_tick   (frame_tick),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    bit         m_vld, m_sof, m_tick;
    logic [7:0] m_data;
    int         m_reg, m_pos, m_und;

    logic [7:0] pay_src;
    logic [7:0] cap_data [FRAME];
    int         last_load_pos;
    bit         last_load;
    int         n_c4, n_tick, n_fill;

    logic [7:0] ptr_tbl [9];

    typedef struct {
        int         r;
        int         c;
        logic [7:0] data;
        int         region;
    } vec_t;
    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic m_reset();
        m_vld = 0; m_sof = 0; m_tick = 0; m_data = 8'h00; m_reg = 0; m_pos = 0; m_und = 0;
    endtask

    // One clock: entered just after a negedge with inputs already driven.
    task automatic step();
        int r, c, rg;
        bit ld, hs;
        logic [7:0] b;
        #1;
        r  = m_pos / COLS;
        c  = m_pos % COLS;
        rg = (c < 9) ? ((r == 3) ? 1 : 0) : ((c == 9) ? 2 : 3);
        ld = rst_n && en && (!m_vld || bus.out_ready);
        chk("row", 32'(row), 32'(r));
        chk("col", 32'(col), 32'(c));
        chk("soh_rd", 32'(bus.soh_rd), 32'(ld && rg == 0));
        chk("poh_rd", 32'(bus.poh_rd), 32'(ld && rg == 2));
        chk("c4_ready", 32'(bus.c4_ready), 32'(ld && rg == 3));
        hs = bus.c4_valid && bus.c4_ready;
        if (bus.c4_ready) n_c4++;
        last_load = 0;
        if (!rst_n) begin
            m_reset();
        end else if (ld) begin
            case (rg)
                0:       b = bus.soh_data;
                1:       b = ptr_tbl[c];
                2:       b = bus.poh_data;
                default: b = bus.c4_valid ? bus.c4_data : 8'h00;
            endcase
            if (rg == 3 && !bus.c4_valid) begin
                n_fill++;
                if (m_und < 65535) m_und++;
            end
            m_vld = 1; m_data = b; m_sof = (m_pos == 0); m_reg = rg;
            m_tick = (m_pos == FRAME - 1);
            last_load = 1; last_load_pos = m_pos;
            m_pos = (m_pos + 1) % FRAME;
        end else begin
            if (bus.out_ready) m_vld = 0;
            m_tick = 0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(m_vld));
        if (m_vld) begin
            chk("out_data", 32'(bus.out_data), 32'(m_data));
            chk("out_sof", 32'(bus.out_sof), 32'(m_sof));
            chk("out_region", 32'(bus.out_region), 32'(m_reg));
        end
        chk("frame_tick", 32'(frame_tick), 32'(m_tick));
        chk("underrun_cnt", 32'(underrun_cnt), 32'(m_und));
        if (frame_tick) n_tick++;
        if (last_load) cap_data[last_load_pos] = bus.out_data;
        if (hs) pay_src = pay_src + 8'd1;
        bus.c4_data = pay_src;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0;
        step();
        rst_n = 1;
        pay_src = 8'h00;
        bus.c4_data = 8'h00;
    endtask

    initial begin
        ptr_tbl = '{8'h6A, 8'h9B, 8'h9B, 8'h0A, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
        vecs[0]  = '{0, 0, 8'hA5, 0};
        vecs[1]  = '{0, 8, 8'hA5, 0};
        vecs[2]  = '{3, 0, 8'h6A, 1};
        vecs[3]  = '{3, 1, 8'h9B, 1};
        vecs[4]  = '{3, 2, 8'h9B, 1};
        vecs[5]  = '{3, 3, 8'h0A, 1};
        vecs[6]  = '{3, 4, 8'hFF, 1};
        vecs[7]  = '{3, 5, 8'hFF, 1};
        vecs[8]  = '{3, 6, 8'h00, 1};
        vecs[9]  = '{3, 7, 8'h00, 1};
        vecs[10] = '{3, 8, 8'h00, 1};
        vecs[11] = '{0, 9, 8'h3C, 2};
        vecs[12] = '{8, 9, 8'h3C, 2};
        vecs[13] = '{0, 10, 8'h00, 3};
        vecs[14] = '{0, 11, 8'h01, 3};
        vecs[15] = '{1, 10, 8'h04, 3};
        vecs[16] = '{2, 10, 8'h08, 3};
        vecs[17] = '{8, 269, 8'h23, 3};

        rst_n = 0; en = 0;
        bus.out_ready = 0; bus.c4_valid = 0;
        bus.soh_data = 8'h00; bus.poh_data = 8'h00; bus.c4_data = 8'h00;
        pay_src = 8'h00;
        n_c4 = 0; n_tick = 0; n_fill = 0;
        last_load_pos = 0; last_load = 0;
        m_reset();
        @(posedge clk);
        @(negedge clk);
        step();

        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_sof", 32'(bus.out_sof), 32'd0);
        chk("rst_out_region", 32'(bus.out_region), 32'd0);
        chk("rst_frame_tick", 32'(frame_tick), 32'd0);
        chk("rst_underrun", 32'(underrun_cnt), 32'd0);
        chk("rst_row", 32'(row), 32'd0);
        chk("rst_col", 32'(col), 32'd0);

        // Full frame, no backpressure, fixed SOH/POH, incrementing payload
        rst_n = 1; en = 1; bus.out_ready = 1; bus.c4_valid = 1;
        bus.soh_data = 8'hA5; bus.poh_data = 8'h3C;
        n_c4 = 0; n_tick = 0;
        for (int i = 0; i < FRAME; i++) step();
        chk("frame_c4_pulses", 32'(n_c4), 32'd2340);
        chk("frame_ticks", 32'(n_tick), 32'd1);
        for (int i = 0; i < 18; i++) begin
            chk($sformatf("vec%0d_data", i), 32'(cap_data[vecs[i].r * COLS + vecs[i].c]), 32'(vecs[i].data));
        end
        for (int p = 0; p < FRAME; p++) begin
            if (p % COLS == 9) chk("poh_col", 32'(cap_data[p]), 32'h3C);
        end

        // Random backpressure, enable and source data
        for (int i = 0; i < 2000; i++) begin
            bus.out_ready = 1'($urandom % 2);
            en            = (($urandom % 8) != 0);
            bus.c4_valid  = (($urandom % 4) != 0);
            bus.soh_data  = 8'($urandom);
            bus.poh_data  = 8'($urandom);
            step();
        end

        // Five payload underruns in row 2
        en = 1; bus.out_ready = 1; bus.c4_valid = 1;
        do_reset();
        n_tick = 0;
        for (int i = 0; i < FRAME; i++) begin
            bus.c4_valid = !(m_pos >= 560 && m_pos <= 564);
            step();
        end
        bus.c4_valid = 1;
        chk("underrun_5", 32'(underrun_cnt), 32'd5);
        chk("underrun_ticks", 32'(n_tick), 32'd1);
        for (int p = 560; p <= 564; p++) chk("fill_byte", 32'(cap_data[p]), 32'h00);
        chk("before_fill", 32'(cap_data[559]), 32'h11);
        chk("after_fill", 32'(cap_data[565]), 32'h12);

        // Reset mid-frame at row 5 col 100
        do_reset();
        for (int i = 0; i < 1450; i++) step();
        chk("pre_rst_row", 32'(row), 32'd5);
        chk("pre_rst_col", 32'(col), 32'd100);
        do_reset();
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_data", 32'(bus.out_data), 32'd0);
        chk("midrst_row", 32'(row), 32'd0);
        chk("midrst_col", 32'(col), 32'd0);
        step();
        chk("restart_pos", 32'(last_load_pos), 32'd0);
        chk("restart_sof", 32'(bus.out_sof), 32'd1);
        chk("restart_region", 32'(bus.out_region), 32'd0);

        // Enable dropped after row 0 col 269 is loaded
        for (int i = 0; i < FRAME && m_pos != 270; i++) step();
        chk("en_reach", 32'(m_pos), 32'd270);
        en = 0;
        for (int i = 0; i < 10; i++) step();
        chk("dis_row", 32'(row), 32'd1);
        chk("dis_col", 32'(col), 32'd0);
        chk("dis_valid", 32'(bus.out_valid), 32'd0);
        en = 1;
        step();
        chk("resume_load", 32'(last_load), 32'd1);
        chk("resume_pos", 32'(last_load_pos), 32'd270);
        chk("resume_region", 32'(bus.out_region), 32'd0);

        // Underrun counter saturation
        do_reset();
        bus.c4_valid = 0;
        n_fill = 0;
        for (int i = 0; i < 80000 && n_fill < 65540; i++) step();
        chk("fill_count", 32'(n_fill), 32'd65540);
        chk("underrun_sat", 32'(underrun_cnt), 32'h0000FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
